// File: rtl/cpu_defs.sv
// Shared BHT types and constants for the branch-history-table port arbiter.
// Optional lookup bypass of queued updates is enabled with BHT_BYPASS_EN.
package cpu_defs;

    localparam int BHT_IDX_W   = 8;
    localparam int BHT_ENTRY_W = 58;

    typedef logic [BHT_IDX_W-1:0] bht_idx_t;

    typedef struct packed {
        logic [20:0] tag;
        logic [31:0] target;
        logic [2:0]  br_type;
        logic [1:0]  count;
    } BHT_entry_t;

    typedef enum logic {
        ARB_INIT = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_t;

    localparam BHT_entry_t BHT_ZERO = '0;

endpackage

// File: rtl/bht_update_fifo.sv
// Circular buffer holding pending BHT updates {idx, data} until a free RAM cycle.
// With BHT_BYPASS_EN it also exposes every slot, oldest first, for the lookup bypass.
module bht_update_fifo #(
    parameter int  DW     = 66,
    parameter int  QDEPTH = 4,
    localparam int AW     = $clog2(QDEPTH),
    localparam int CW     = AW + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_flush,
    input  logic                          i_push,
    input  logic [DW-1:0]                 i_push_data,
    input  logic                          i_pop,
    output logic [DW-1:0]                 o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [CW-1:0]                 o_count
`ifdef BHT_BYPASS_EN
    ,
    output logic [QDEPTH-1:0][DW-1:0]     o_entries,
    output logic [QDEPTH-1:0]             o_valid
`endif
);

    logic [DW-1:0] r_mem [QDEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    // Caller guarantees no push while full and no pop while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(QDEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

`ifdef BHT_BYPASS_EN
    // Slot k is the k-th oldest pending update; higher k is younger.
    for (genvar k = 0; k < QDEPTH; k++) begin : g_slot
        assign o_entries[k] = r_mem[r_rd_ptr + AW'(k)];
        assign o_valid[k]   = (CW'(k) < r_count);
    end
`endif

endmodule

// File: rtl/bht_port_arbiter.sv
// Arbitrates the single-port BHT SRAM between decode lookups and buffered execute updates,
// zero-filling the table after reset/clear. Define BHT_BYPASS_EN to forward queued updates to lookups.
module bht_port_arbiter
    import cpu_defs::*;
#(
    parameter int IDX_W        = BHT_IDX_W,
    parameter int ENTRY_W      = BHT_ENTRY_W,
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bht_clear,
    input  logic               lk_req,
    input  logic [IDX_W-1:0]   lk_idx,
    output logic               lk_ready,
    output logic               lk_rvalid,
    output logic [ENTRY_W-1:0] lk_rdata,
    input  logic               up_valid,
    input  logic [IDX_W-1:0]   up_idx,
    input  logic [ENTRY_W-1:0] up_data,
    output logic               up_ready,
    output logic               ram_en,
    output logic               ram_we,
    output logic [IDX_W-1:0]   ram_addr,
    output logic [ENTRY_W-1:0] ram_wdata,
    input  logic [ENTRY_W-1:0] ram_rdata,
    output logic               init_busy
);

    localparam int QW = IDX_W + ENTRY_W;
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [IDX_W-1:0]   r_fill_cnt;
    logic [IDX_W-1:0]   w_fill_nxt;
    logic [SW-1:0]      r_starve;
    logic [SW-1:0]      w_starve_nxt;
    logic               r_lk_rvalid;
    logic [ENTRY_W-1:0] r_lk_rdata_hold;

    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic [QW-1:0]      w_head;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic               w_force_wr;

`ifdef BHT_BYPASS_EN
    logic [QDEPTH-1:0][QW-1:0] w_fifo_entries;
    logic [QDEPTH-1:0]         w_fifo_valid;
    logic                      w_byp_hit;
    logic [ENTRY_W-1:0]        w_byp_data;
    logic                      r_byp_hit;
    logic [ENTRY_W-1:0]        r_byp_data;
`endif

    bht_update_fifo #(
        .DW     (QW),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_push_data ({up_idx, up_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
`ifdef BHT_BYPASS_EN
        ,
        .o_entries   (w_fifo_entries),
        .o_valid     (w_fifo_valid)
`endif
    );

    // A write is forced when the queue cannot grow or lookups have deferred it long enough.
    assign w_force_wr = w_full || (!w_empty && (r_starve >= SW'(STARVE_LIMIT)));

    always_comb begin
        w_state_nxt  = r_state;
        w_fill_nxt   = r_fill_cnt;
        w_starve_nxt = r_starve;
        init_busy    = 1'b0;
        lk_ready     = 1'b0;
        up_ready     = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ARB_INIT: begin
                init_busy = 1'b1;
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_fill_cnt;
                ram_wdata = ENTRY_W'(BHT_ZERO);
                if (bht_clear) begin
                    w_fill_nxt = '0;
                end else begin
                    w_fill_nxt = r_fill_cnt + 1'b1;
                    if (&r_fill_cnt) begin
                        w_state_nxt = ARB_RUN;
                    end
                end
            end
            ARB_RUN: begin
                if (bht_clear) begin
                    w_flush      = 1'b1;
                    w_starve_nxt = '0;
                    w_fill_nxt   = '0;
                    w_state_nxt  = ARB_INIT;
                end else begin
                    up_ready = (w_count < CW'(QDEPTH));
                    w_push   = up_valid && up_ready;
                    if (lk_req && !w_force_wr) begin
                        ram_en   = 1'b1;
                        ram_addr = lk_idx;
                        lk_ready = 1'b1;
                        if (!w_empty && (r_starve < SW'(STARVE_LIMIT))) begin
                            w_starve_nxt = r_starve + 1'b1;
                        end
                    end else if (!w_empty) begin
                        ram_en       = 1'b1;
                        ram_we       = 1'b1;
                        ram_addr     = w_head[ENTRY_W +: IDX_W];
                        ram_wdata    = w_head[ENTRY_W-1:0];
                        w_pop        = 1'b1;
                        w_starve_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ARB_INIT;
            r_fill_cnt      <= '0;
            r_starve        <= '0;
            r_lk_rvalid     <= 1'b0;
            r_lk_rdata_hold <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_cnt  <= w_fill_nxt;
            r_starve    <= w_starve_nxt;
            r_lk_rvalid <= lk_ready;
            if (r_lk_rvalid) begin
                r_lk_rdata_hold <= lk_rdata;
            end
        end
    end

    assign lk_rvalid = r_lk_rvalid;

`ifdef BHT_BYPASS_EN
    // Youngest match wins; the update pushed in the grant cycle is not yet in the slots.
    always_comb begin
        w_byp_hit  = 1'b0;
        w_byp_data = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            if (w_fifo_valid[k] && (w_fifo_entries[k][ENTRY_W +: IDX_W] == lk_idx)) begin
                w_byp_hit  = 1'b1;
                w_byp_data = w_fifo_entries[k][ENTRY_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_hit <= lk_ready && w_byp_hit;
            if (lk_ready) begin
                r_byp_data <= w_byp_data;
            end
        end
    end

    assign lk_rdata = r_lk_rvalid ? (r_byp_hit ? r_byp_data : ram_rdata) : r_lk_rdata_hold;
`else
    assign lk_rdata = r_lk_rvalid ? ram_rdata : r_lk_rdata_hold;
`endif

endmodule
